// File: rtl/vm_session_timer_pkg.sv
// vm_timer_pkg: shared definitions for the vending-machine session timer.
//   - vm_state_e       : FSM state encoding (IDLE=0, ACTIVE=1, RET_DELAY=2, RETURNING=3)
//   - DEF_WAIT_TIME    : default inactivity timeout in cycles (same value as the
//                        vending_machine_def kWaitTime constant)
//   - DEF_RETURN_DELAY : default cycles from accepted return trigger to return request
// No ports; imported by the timer top and its interface users.
package vm_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_RET_DELAY = 2'd2,
        ST_RETURNING = 2'd3
    } vm_state_e;

    localparam int DEF_WAIT_TIME    = 100;
    localparam int DEF_RETURN_DELAY = 3;

endpackage

// File: rtl/vm_session_timer_if.sv
// vm_session_timer_if: bundles the customer-input and change-return signals of
// the session timer.
//   master modport : drives the customer inputs and i_return_done, observes outputs
//   slave modport  : the timer itself
// Signals: i_trigger_return, i_input_coin[NUM_COINS], i_select_item[NUM_ITEMS],
//          i_available_item[NUM_ITEMS], i_return_done, o_wait_time[TIMER_W],
//          o_state[2], o_return_req, o_timeout, and o_warn when
//          VM_SESSION_TIMER_WARN_EN is defined.
// Return handshake: o_return_req is a level that stays high from the cycle the
// timer enters RETURNING until the first clock edge that samples i_return_done
// high; it drops on that edge. i_return_done is ignored while o_return_req is low.
interface vm_session_timer_if #(
    parameter int NUM_COINS = 3,
    parameter int NUM_ITEMS = 4,
    parameter int TIMER_W   = 8
);
    logic                 i_trigger_return;
    logic [NUM_COINS-1:0] i_input_coin;
    logic [NUM_ITEMS-1:0] i_select_item;
    logic [NUM_ITEMS-1:0] i_available_item;
    logic                 i_return_done;
    logic [TIMER_W-1:0]   o_wait_time;
    logic [1:0]           o_state;
    logic                 o_return_req;
    logic                 o_timeout;
`ifdef VM_SESSION_TIMER_WARN_EN
    logic                 o_warn;
`endif

    modport master (
        output i_trigger_return, i_input_coin, i_select_item, i_available_item, i_return_done,
        input  o_wait_time, o_state, o_return_req, o_timeout
`ifdef VM_SESSION_TIMER_WARN_EN
        , o_warn
`endif
    );

    modport slave (
        input  i_trigger_return, i_input_coin, i_select_item, i_available_item, i_return_done,
        output o_wait_time, o_state, o_return_req, o_timeout
`ifdef VM_SESSION_TIMER_WARN_EN
        , o_warn
`endif
    );

endinterface

// File: rtl/vm_session_timer_load_down_counter.sv
// vm_load_down_counter: loadable down counter that saturates at zero.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (count -> 0)
//   load_i         : load load_val_i on the next edge (has priority over en_i)
//   load_val_i     : value to load
//   en_i           : decrement on the next edge; no effect when count is 0
//   count_o        : current count
//   zero_o         : count_o == 0
module vm_load_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/vm_session_timer.sv
// vm_session_timer: customer inactivity / return-request timer with a
// change-return handshake toward the dispenser.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   bus    : vm_session_timer_if.slave (customer inputs, return handshake,
//            o_wait_time counter value, o_state FSM state, o_timeout pulse)
// Optional: define VM_SESSION_TIMER_WARN_EN to add bus.o_warn, high while ACTIVE
// with 0 < counter <= WARN_THRESH.
// All outputs are registered; o_state is the FSM state for observation.
module vm_session_timer
    import vm_timer_pkg::*;
#(
    parameter int NUM_COINS    = 3,
    parameter int NUM_ITEMS    = 4,
    parameter int TIMER_W      = 8,
    parameter int WAIT_TIME    = DEF_WAIT_TIME,
    parameter int RETURN_DELAY = DEF_RETURN_DELAY,
    parameter int WARN_THRESH  = 10
) (
    input  logic              clk,
    input  logic              reset,
    vm_session_timer_if.slave bus
);

    // Loads must fit the counter so it can never wrap.
    if (WAIT_TIME < 1 || longint'(WAIT_TIME) >= (longint'(1) << TIMER_W)) begin : g_bad_wait
        $error("vm_session_timer: WAIT_TIME out of range");
    end
    if (RETURN_DELAY < 0 || longint'(RETURN_DELAY) >= (longint'(1) << TIMER_W)) begin : g_bad_delay
        $error("vm_session_timer: RETURN_DELAY out of range");
    end
    if (WARN_THRESH < 0 || longint'(WARN_THRESH) >= (longint'(1) << TIMER_W)) begin : g_bad_warn
        $error("vm_session_timer: WARN_THRESH out of range");
    end

    localparam logic [TIMER_W-1:0] LOAD_WAIT  = TIMER_W'(WAIT_TIME);
    localparam logic [TIMER_W-1:0] LOAD_DELAY = TIMER_W'(RETURN_DELAY);

    vm_state_e state_q, state_d;
    logic      trig_q;
    logic      timeout_q, timeout_d;
    logic      return_req_q;

    logic [NUM_COINS-1:0] coins;
    logic [NUM_ITEMS-1:0] picks;
    logic                 activity;
    logic                 trig;

    logic               cnt_load;
    logic [TIMER_W-1:0] cnt_val;
    logic               cnt_en;
    logic [TIMER_W-1:0] cnt;
    logic               cnt_zero;

    assign coins    = bus.i_input_coin;
    assign picks    = bus.i_select_item & bus.i_available_item;
    assign activity = (|coins) | (|picks);
    // Rising edge only: a held button is accepted once.
    assign trig     = bus.i_trigger_return & ~trig_q;

    vm_load_down_counter #(.W(TIMER_W)) u_counter (
        .clk        (clk),
        .rst        (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .count_o    (cnt),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_en    = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_load = 1'b1;
                if (trig) begin
                    state_d = ST_RET_DELAY;
                    cnt_val = LOAD_DELAY;
                end else if (activity) begin
                    state_d = ST_ACTIVE;
                    cnt_val = LOAD_WAIT;
                end
            end
            ST_ACTIVE: begin
                if (trig) begin
                    state_d  = ST_RET_DELAY;
                    cnt_load = 1'b1;
                    cnt_val  = LOAD_DELAY;
                end else if (activity) begin
                    cnt_load = 1'b1;
                    cnt_val  = LOAD_WAIT;
                end else if (!cnt_zero) begin
                    cnt_en = 1'b1;
                end else begin
                    state_d   = ST_RETURNING;
                    timeout_d = 1'b1;
                end
            end
            ST_RET_DELAY: begin
                if (!cnt_zero) begin
                    cnt_en = 1'b1;
                end else begin
                    state_d = ST_RETURNING;
                end
            end
            ST_RETURNING: begin
                cnt_load = 1'b1;
                if (bus.i_return_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            trig_q       <= 1'b0;
            timeout_q    <= 1'b0;
            return_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_q       <= bus.i_trigger_return;
            timeout_q    <= timeout_d;
            return_req_q <= (state_d == ST_RETURNING);
        end
    end

    assign bus.o_wait_time  = cnt;
    assign bus.o_state      = state_q;
    assign bus.o_return_req = return_req_q;
    assign bus.o_timeout    = timeout_q;

`ifdef VM_SESSION_TIMER_WARN_EN
    // Warn is evaluated on the values the counter and state will hold after the
    // edge so that it lines up with o_wait_time and o_state.
    logic [TIMER_W-1:0] cnt_next;
    logic               warn_q;
    logic               warn_d;

    assign cnt_next = cnt_load ? cnt_val : (cnt_en ? cnt - 1'b1 : cnt);
    assign warn_d   = (state_d == ST_ACTIVE) && (cnt_next != '0)
                      && (cnt_next <= TIMER_W'(WARN_THRESH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign bus.o_warn = warn_q;
`endif

endmodule

// File: tb/tb_vm_session_timer.sv
// tb_vm_session_timer: directed scenarios plus randomized traffic for
// vm_session_timer, checked every cycle against a behavioural model.
module tb_vm_session_timer;
    localparam int NC  = 3;
    localparam int NI  = 4;
    localparam int TW  = 8;
    localparam int WT  = 5;
    localparam int RD  = 3;
    localparam int WTH = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vm_session_timer_if #(.NUM_COINS(NC), .NUM_ITEMS(NI), .TIMER_W(TW)) bus ();

    vm_session_timer #(
        .NUM_COINS    (NC),
        .NUM_ITEMS    (NI),
        .TIMER_W      (TW),
        .WAIT_TIME    (WT),
        .RETURN_DELAY (RD),
        .WARN_THRESH  (WTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 counting inactivity, 2 delaying return,
    // 3 waiting for the dispenser.
    int m_phase;
    int m_cnt;
    bit m_timeout;
    bit m_req;
    bit m_warn;
    bit m_btn_prev;
    logic [TW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_cnt      = 0;
        m_timeout  = 0;
        m_req      = 0;
        m_warn     = 0;
        m_btn_prev = 0;
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    task automatic model_step(input logic btn, input logic [NC-1:0] coin,
                              input logic [NI-1:0] sel, input logic [NI-1:0] avail,
                              input logic done);
        bit busy;
        bit pressed;
        busy       = (coin != 0) || ((sel & avail) != 0);
        pressed    = btn && !m_btn_prev;
        m_btn_prev = btn;
        m_timeout  = 0;
        if (m_phase == 0) begin
            if (pressed)   begin m_phase = 2; m_cnt = RD; end
            else if (busy) begin m_phase = 1; m_cnt = WT; end
            else m_cnt = 0;
        end else if (m_phase == 1) begin
            if (pressed)         begin m_phase = 2; m_cnt = RD; end
            else if (busy)       m_cnt = WT;
            else if (m_cnt > 0)  m_cnt = m_cnt - 1;
            else begin m_phase = 3; m_timeout = 1; end
        end else if (m_phase == 2) begin
            if (m_cnt > 0) m_cnt = m_cnt - 1;
            else m_phase = 3;
        end else begin
            m_cnt = 0;
            if (done) m_phase = 0;
        end
        m_req  = (m_phase == 3);
        m_warn = (m_phase == 1) && (m_cnt > 0) && (m_cnt <= WTH);
        exp_q.push_back(TW'(m_cnt));
    endtask

    task automatic check_all();
        logic [TW-1:0] exp_cnt;
        exp_cnt = exp_q.pop_front();
        check("state",      32'(bus.o_state),      32'(m_phase));
        check("wait_time",  32'(bus.o_wait_time),  32'(exp_cnt));
        check("return_req", 32'(bus.o_return_req), 32'(m_req));
        check("timeout",    32'(bus.o_timeout),    32'(m_timeout));
`ifdef VM_SESSION_TIMER_WARN_EN
        check("warn",       32'(bus.o_warn),       32'(m_warn));
`endif
    endtask

    task automatic set_inputs(input logic btn, input logic [NC-1:0] coin,
                              input logic [NI-1:0] sel, input logic [NI-1:0] avail,
                              input logic done);
        bus.i_trigger_return = btn;
        bus.i_input_coin     = coin;
        bus.i_select_item    = sel;
        bus.i_available_item = avail;
        bus.i_return_done    = done;
    endtask

    task automatic drive(input logic btn, input logic [NC-1:0] coin,
                         input logic [NI-1:0] sel, input logic [NI-1:0] avail,
                         input logic done);
        @(negedge clk);
        set_inputs(btn, coin, sel, avail, done);
        model_step(btn, coin, sel, avail, done);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0);
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic async_reset();
        @(negedge clk);
        #2;
        set_inputs(1'b0, '0, '0, '0, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic btn;
        logic [NC-1:0] coin;
        logic [NI-1:0] sel;
        logic [NI-1:0] avail;
        logic done;
        int busy_pct;

        reset = 1'b1;
        set_inputs(1'b0, '0, '0, '0, 1'b0);
        #3;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Single coin, then silence: count 5..0, timeout, wait for dispenser.
        drive(1'b0, 3'b001, '0, '0, 1'b0);
        idle(9);
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(2);

        // Coins every 4 cycles keep the session alive.
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 3'b010, '0, '0, 1'b0);
            idle(3);
        end
        // Unavailable item at counter 2 must not reload.
        drive(1'b0, '0, 4'b0001, 4'b1110, 1'b0);
        idle(4);
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(1);

        // Trigger held 10 cycles while active; coins during the delay are ignored.
        drive(1'b0, 3'b100, '0, '0, 1'b0);
        for (int k = 0; k < 10; k++) drive(1'b1, (k % 2 == 1) ? 3'b001 : 3'b000, '0, '0, 1'b0);
        idle(3);
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(1);

        // Trigger and coin together in idle: return path wins.
        drive(1'b1, 3'b001, 4'b0010, 4'b0010, 1'b0);
        drive(1'b0, 3'b001, '0, '0, 1'b1);
        idle(5);
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(1);

        // Reset in the middle of an active countdown.
        drive(1'b0, 3'b001, '0, '0, 1'b0);
        idle(2);
        async_reset();
        idle(2);

        // Randomized traffic with varying activity density.
        btn = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            case (i / 300)
                0:       busy_pct = 50;
                1:       busy_pct = 15;
                2:       busy_pct = 3;
                3:       busy_pct = 0;
                default: busy_pct = 30;
            endcase
            if ($urandom_range(0, 5) == 0) btn = ~btn;
            coin  = ($urandom_range(0, 99) < busy_pct) ? NC'(1 << $urandom_range(0, NC - 1)) : '0;
            sel   = ($urandom_range(0, 99) < busy_pct) ? NI'($urandom) : '0;
            avail = NI'($urandom);
            done  = ($urandom_range(0, 3) == 0);
            drive(btn, coin, sel, avail, done);
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
                btn = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
